mem_stage_controller: RTL and testbench
=======================================

Name: mem_stage_controller

Overview:
- Sequences the MEM stage of the 5-stage pipeline around a variable-latency data memory.
- Inspects the control and data currently held in the EX/MEM pipeline register and issues a single-word valid/ready request to the data memory.
- Raises stall_out to freeze the EX/MEM register and all upstream stages until the response returns.
- Delivers load data and completion/error pulses toward MEM/WB.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+WAIT before abort; legal range 1..65535.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-high
mem_read_in  input  1  MemRead from EX/MEM output
mem_write_in  input  1  MemWrite from EX/MEM output
addr_in  input  32  ALU result (byte address) from EX/MEM
wdata_in  input  32  rs2 data (store data) from EX/MEM
stall_out  output  1  1 = upstream must hold EX/MEM and earlier stages unchanged
dmem_req_valid  output  1  memory request valid
dmem_req_ready  input  1  memory accepts request
dmem_req_we  output  1  1 = write, 0 = read
dmem_req_addr  output  32  word-aligned request address
dmem_req_wdata  output  32  store data
dmem_rsp_valid  input  1  response/ack valid; reads and writes both receive one
dmem_rsp_rdata  input  32  read data, meaningful for reads
mem_rdata_out  output  32  last load data; held until the next load completes
access_done  output  1  1-cycle pulse when an access completes (ok or error)
misalign_err  output  1  1-cycle pulse: addr_in[1:0] != 0
ctrl_err  output  1  1-cycle pulse: mem_read_in and mem_write_in both 1
timeout_err  output  1  1-cycle pulse: access aborted by timeout

Behaviour:
- Reset (async, immediate): state=IDLE, timeout counter=0. All outputs 0, including mem_rdata_out and dmem_req_*. Any outstanding memory transaction is abandoned. A dmem_rsp_valid arriving after reset outside WAIT is ignored.
- States: IDLE, REQ, WAIT, DONE. Registered state; stall_out is combinational.
- IDLE:
  - No access (both enables 0): stall_out=0, stay IDLE. No pulses.
  - Both enables 1: ctrl_err=1 and access_done=1 in this cycle (combinational); no request; stall_out=0; stay IDLE.
  - Access with addr_in[1:0]!=0: misalign_err=1 and access_done=1 this cycle; no request; stall_out=0; stay IDLE.
  - Aligned access: stall_out=1. On the edge, latch we=mem_write_in, addr, wdata; clear counter; go REQ.
- REQ: dmem_req_valid=1 with stable we/addr/wdata; stall_out=1; counter increments each cycle.
  - valid&ready → WAIT.
  - Counter reaching TIMEOUT takes priority → DONE with abort flag.
- WAIT: stall_out=1; counter continues.
  - dmem_rsp_valid=1 → if read, capture rdata into mem_rdata_out; go DONE.
  - Timeout → DONE with abort flag; mem_rdata_out unchanged.
  - If rsp_valid and timeout occur in the same cycle, the response wins.
- DONE: stall_out=0; access_done=1; timeout_err=1 if aborted. Go IDLE unconditionally, so the same EX/MEM instruction is never re-issued.
- dmem_rsp_valid outside WAIT: ignored.
- Latency with ready=1 and a response the cycle after handshake: detect cycle C0 (stall), REQ C1 (stall), WAIT C2 (rsp; stall), DONE C3 (no stall). That is 3 stall cycles; the minimum is also 3.
- Errors and timeout never write mem_rdata_out.
- A reset in REQ/WAIT drops dmem_req_valid immediately.

Test Plan:
- Non-memory traffic: both enables 0 for 10 cycles → stall_out, dmem_req_valid, and all pulses stay 0.
- Load 0x0000_0010, ready=1, rsp next cycle with rdata 0xDEADBEEF → stall_out high exactly 3 cycles; req_addr=0x10, we=0; mem_rdata_out=0xDEADBEEF and access_done pulse in DONE.
- Store addr 0x24 data 0x1234_5678, ready low 4 cycles then high, ack 2 cycles later → dmem_req_valid/addr/wdata stable while ready=0; stall_out high for the whole wait; mem_rdata_out unchanged.
- Misaligned load addr 0x13 → misalign_err=1 and access_done=1 same cycle; no request; stall_out=0. Both enables=1 → ctrl_err pulse, no request.
- TIMEOUT=8, load with ready never asserted → timeout_err and access_done pulse in DONE; 8 REQ-cycle stall observed; mem_rdata_out keeps its prior value.
- Assert rst during WAIT, then rsp_valid=1 after release → all outputs 0 immediately; state IDLE; stale response ignored; mem_rdata_out stays 0.

Source files
------------

// File: rtl/mem_stage_controller.sv
// MEM-stage sequencer: issues one data-memory request per EX/MEM access,
// stalls upstream until the response (or a timeout) and reports completion.
module mem_stage_controller #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic [31:0] mem_rdata_out,
  output logic        access_done,
  output logic        misalign_err,
  output logic        ctrl_err,
  output logic        timeout_err
);

  localparam int unsigned CNT_W = 16;
  // Counter value seen during the TIMEOUT-th cycle spent in REQ+WAIT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             abort;
  logic             abort_next;
  logic             launch;
  logic             capture;
  logic             timeout_hit;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and combinational outputs; everything held low during reset.
  always_comb begin
    state_next     = state;
    abort_next     = abort;
    launch         = 1'b0;
    capture        = 1'b0;
    stall_out      = 1'b0;
    dmem_req_valid = 1'b0;
    access_done    = 1'b0;
    misalign_err   = 1'b0;
    ctrl_err       = 1'b0;
    timeout_err    = 1'b0;
    timeout_hit    = (cnt == CNT_LAST);
    if (!rst) begin
      case (state)
        IDLE: begin
          if (mem_read_in && mem_write_in) begin
            ctrl_err    = 1'b1;
            access_done = 1'b1;
          end else if (mem_read_in || mem_write_in) begin
            if (addr_in[1:0] != 2'b00) begin
              misalign_err = 1'b1;
              access_done  = 1'b1;
            end else begin
              stall_out  = 1'b1;
              launch     = 1'b1;
              abort_next = 1'b0;
              state_next = REQ;
            end
          end
        end
        REQ: begin
          stall_out      = 1'b1;
          dmem_req_valid = 1'b1;
          if (timeout_hit) begin
            abort_next = 1'b1;
            state_next = DONE;
          end else if (dmem_req_ready) begin
            state_next = WAIT;
          end
        end
        WAIT: begin
          stall_out = 1'b1;
          if (dmem_rsp_valid) begin
            capture    = ~dmem_req_we;
            state_next = DONE;
          end else if (timeout_hit) begin
            abort_next = 1'b1;
            state_next = DONE;
          end
        end
        DONE: begin
          access_done = 1'b1;
          timeout_err = abort;
          state_next  = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Request latch, timeout counter, abort flag and load-data holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      abort          <= 1'b0;
      dmem_req_we    <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_wdata <= '0;
      mem_rdata_out  <= '0;
    end else begin
      abort <= abort_next;
      if (launch) begin
        dmem_req_we    <= mem_write_in;
        dmem_req_addr  <= {addr_in[31:2], 2'b00};
        dmem_req_wdata <= wdata_in;
        cnt            <= '0;
      end else if (state == REQ || state == WAIT) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (capture) begin
        mem_rdata_out <= dmem_rsp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_controller.sv
// Directed bench for mem_stage_controller (TIMEOUT = 8).
module tb_mem_stage_controller;

  logic        clk;
  logic        rst;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        stall_out;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic [31:0] mem_rdata_out;
  logic        access_done;
  logic        misalign_err;
  logic        ctrl_err;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_controller #(.TIMEOUT(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .addr_in        (addr_in),
    .wdata_in       (wdata_in),
    .stall_out      (stall_out),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .mem_rdata_out  (mem_rdata_out),
    .access_done    (access_done),
    .misalign_err   (misalign_err),
    .ctrl_err       (ctrl_err),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access from detect to DONE, with ready raised after rdy_after REQ
  // cycles and the response given in WAIT cycle number rsp_after.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input int rdy_after, input int rsp_after,
                            input logic [31:0] rsp_data, output int stalls, output int reqs,
                            output logic done_seen, output logic to_seen, output logic stable_ok);
    int   waits;
    logic hs;
    stalls = 0; reqs = 0; waits = 0; hs = 1'b0;
    done_seen = 1'b0; to_seen = 1'b0; stable_ok = 1'b1;
    step();
    mem_read_in = rd; mem_write_in = wr; addr_in = a; wdata_in = wd;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      @(negedge clk);
      dmem_rsp_valid = 1'b0;
      if (stall_out) stalls++;
      if (access_done) begin
        done_seen = 1'b1;
        to_seen   = timeout_err;
      end else if (dmem_req_valid) begin
        reqs++;
        if (dmem_req_addr !== {a[31:2], 2'b00} || dmem_req_wdata !== wd || dmem_req_we !== wr)
          stable_ok = 1'b0;
        dmem_req_ready = (reqs > rdy_after);
        hs = dmem_req_ready;
      end else if (hs && stall_out) begin
        waits++;
        dmem_req_ready = 1'b0;
        if (waits == rsp_after) begin
          dmem_rsp_valid = 1'b1;
          dmem_rsp_rdata = rsp_data;
        end
      end
    end
    check("access_completed", 64'(done_seen), 64'(1));
    step();
    mem_read_in = 1'b0; mem_write_in = 1'b0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          stalls;
    int          reqs;
    logic        done_seen;
    logic        to_seen;
    logic        stable_ok;
    logic [5:0]  acc;

    rst = 1'b1;
    mem_read_in = 1'b0; mem_write_in = 1'b0;
    addr_in = '0; wdata_in = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 64'({stall_out, dmem_req_valid, access_done, misalign_err,
                             ctrl_err, timeout_err, dmem_req_we}), 64'(0));
    check("reset_addr", 64'(dmem_req_addr), 64'(0));
    check("reset_rdata", 64'(mem_rdata_out), 64'(0));
    step();
    rst = 1'b0;

    // No memory traffic for 10 cycles, including misaligned addresses.
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      addr_in = 32'h3 + 32'(i);
      @(negedge clk);
      acc |= {stall_out, dmem_req_valid, access_done, misalign_err, ctrl_err, timeout_err};
    end
    check("idle_quiet", 64'(acc), 64'(0));

    // Aligned load, minimum latency.
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 1, 32'hDEAD_BEEF,
               stalls, reqs, done_seen, to_seen, stable_ok);
    check("load_stalls", 64'(stalls), 64'(3));
    check("load_reqs", 64'(reqs), 64'(1));
    check("load_req_fields", 64'(stable_ok), 64'(1));
    check("load_no_timeout", 64'(to_seen), 64'(0));
    check("load_rdata", 64'(mem_rdata_out), 64'h0000_0000_DEAD_BEEF);
    @(negedge clk);
    check("load_after_idle", 64'({stall_out, access_done, dmem_req_valid}), 64'(0));

    // Store with back-pressure then a delayed ack.
    run_access(1'b0, 1'b1, 32'h0000_0024, 32'h1234_5678, 4, 2, 32'hBAD0_BAD0,
               stalls, reqs, done_seen, to_seen, stable_ok);
    check("store_stalls", 64'(stalls), 64'(8));
    check("store_reqs", 64'(reqs), 64'(5));
    check("store_req_stable", 64'(stable_ok), 64'(1));
    check("store_no_timeout", 64'(to_seen), 64'(0));
    check("store_rdata_kept", 64'(mem_rdata_out), 64'h0000_0000_DEAD_BEEF);

    // Misaligned load: pulses in the same cycle, no request.
    mem_read_in = 1'b1; addr_in = 32'h0000_0013;
    @(negedge clk);
    check("misalign_pulse", 64'({misalign_err, access_done, ctrl_err, stall_out, dmem_req_valid}),
          64'(5'b11000));
    step();
    mem_read_in = 1'b0;
    @(negedge clk);
    check("misalign_no_req", 64'({dmem_req_valid, stall_out, access_done}), 64'(0));

    // Both enables: control error, no request.
    step();
    mem_read_in = 1'b1; mem_write_in = 1'b1; addr_in = 32'h0000_0020;
    @(negedge clk);
    check("ctrl_pulse", 64'({ctrl_err, access_done, misalign_err, stall_out, dmem_req_valid}),
          64'(5'b11000));
    step();
    mem_read_in = 1'b0; mem_write_in = 1'b0;
    @(negedge clk);
    check("ctrl_no_req", 64'({dmem_req_valid, stall_out, access_done}), 64'(0));

    // Load that is never accepted: abort after 8 REQ cycles.
    run_access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 1000, 1000, 32'h5555_5555,
               stalls, reqs, done_seen, to_seen, stable_ok);
    check("timeout_reqs", 64'(reqs), 64'(8));
    check("timeout_stalls", 64'(stalls), 64'(9));
    check("timeout_flag", 64'(to_seen), 64'(1));
    check("timeout_rdata_kept", 64'(mem_rdata_out), 64'h0000_0000_DEAD_BEEF);

    // Reset in WAIT, then a stale response.
    step();
    mem_read_in = 1'b1; addr_in = 32'h0000_0040; dmem_req_ready = 1'b1;
    step();
    @(negedge clk);
    check("rst_test_req", 64'({stall_out, dmem_req_valid}), 64'(2'b11));
    step();
    dmem_req_ready = 1'b0;
    @(negedge clk);
    check("rst_test_wait", 64'({stall_out, dmem_req_valid}), 64'(2'b10));
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_ctrl", 64'({stall_out, dmem_req_valid, access_done, misalign_err,
                                 ctrl_err, timeout_err, dmem_req_we}), 64'(0));
    check("rst_async_addr", 64'(dmem_req_addr), 64'(0));
    check("rst_async_rdata", 64'(mem_rdata_out), 64'(0));
    @(negedge clk);
    check("rst_held_stall", 64'({stall_out, dmem_req_valid}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0; mem_read_in = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("stale_rsp_ctrl", 64'({stall_out, access_done, dmem_req_valid}), 64'(0));
    step();
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    check("stale_rsp_rdata", 64'(mem_rdata_out), 64'(0));
    check("stale_rsp_done", 64'({access_done, timeout_err}), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
